l2_l3_batch_fifo: RTL and testbench
===================================

Name: l2_l3_batch_fifo

Overview:
- Frame-aware batch FIFO that sits directly upstream of conv2d_layer3 (L3).
- Buffers 16-channel int8 pixels produced by the L2 stage (14x14x16 map, raster order).
- Tells L3 when a full 28-pixel batch (two image rows) is available, and flags the final batch of the frame.
- Serves pixels on L3's rd_en_out with one-cycle read latency.

Parameters:
- CH, 16, channels per pixel
- DATA_W, 8, bits per channel
- DEPTH, 64, pixel entries; must be a power of 2 and >= 2*BATCH_SIZE
- BATCH_SIZE, 28, pixels per batch
- TOTAL_PIXELS, 196, pixels per frame; must be a multiple of BATCH_SIZE

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  L2 pixel valid
- wr_data  in  CH*DATA_W  pixel; channel c occupies bits [8c+7:8c]
- wr_ready  out  1  write will be accepted this cycle
- rd_en  in  1  from L3 rd_en_out
- rd_valid  out  1  to L3 in_valid
- rd_data  out  CH*DATA_W  to L3 in_data0..15
- fifo_empty  out  1  count==0
- fifo_batch_ready  out  1  a full batch is buffered
- fifo_last_batch  out  1  buffered data is the frame's final batch
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is read
- overflow  out  1  sticky: write attempted while wr_ready=0
- underflow  out  1  sticky: rd_en while empty

Behaviour:
- Reset (async assert, sync release): all pointers, counters, flags and rd_data cleared; rd_valid=0, frame_done=0, overflow=0, underflow=0, fifo_empty=1, fifo_batch_ready=0, fifo_last_batch=0, wr_ready=1, FSM=S_FILL.
- Reset mid-frame discards all buffered data.
- Status outputs are decoded from registered state only; there is no combinational input-to-output path.
- Storage is a circular buffer:
  - wr_ptr/rd_ptr are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - wr_total/rd_total are 8-bit per-frame counters.
- Write rules:
  - Write accepted iff wr_en && wr_ready, where wr_ready = (count<DEPTH) && (wr_total<TOTAL_PIXELS) && state!=S_WRAP.
  - Rejected write: data dropped, overflow set.
- Read rules:
  - Read accepted iff rd_en && !fifo_empty.
  - rd_data is registered and rd_valid pulses the following cycle (latency 1).
  - Rejected read: underflow set, rd_valid stays 0.
  - rd_data holds its value when no read is accepted.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full and empty are evaluated on current-cycle count:
  - At full, a concurrent read does not enable the write.
  - At empty, a concurrent write does not satisfy the read.
- Write-to-read latency: a pixel written at cycle t is counted at t+1; rd_en at t+1 yields rd_valid at t+2.
- fifo_batch_ready = (count >= BATCH_SIZE).
- fifo_last_batch = 1 in S_TAIL while rd_total >= TOTAL_PIXELS-BATCH_SIZE or count>0 with wr_total==TOTAL_PIXELS and TOTAL_PIXELS-rd_total <= BATCH_SIZE. It remains high until S_WRAP.
- FSM:
  - S_FILL: accepting frame writes. Go to S_TAIL when the accepted write makes wr_total==TOTAL_PIXELS.
  - S_TAIL: writes blocked. Go to S_WRAP when the accepted read makes rd_total==TOTAL_PIXELS.
  - S_WRAP: one cycle. Clear wr_total, rd_total and last_batch; pulse frame_done; go to S_FILL. Writes are blocked during this cycle, and the next frame's writes are accepted from the following cycle.
- Sticky flags clear only on reset.

Decomposition:
- Shared package (cnn_pkg): DATA_W, CH, and per-layer IMG_W/IMG_H constants. TOTAL_PIXELS and BATCH_SIZE for L3 are derived from IMG_W=14, IMG_H=14 (BATCH_SIZE = 2*IMG_W).
- FSM state encoding is local.
- One sub-module: fifo_mem_1r1w, a DEPTH x (CH*DATA_W) register array with synchronous write and registered read.
- Pointers, counters, flags and FSM stay in the top module.

Test Plan:
- Reset, then write 27 pixels (channel c = index*(c+1) mod 256) -> fifo_batch_ready=0, count 27; the 28th write -> fifo_batch_ready=1 next cycle, fifo_empty=0.
- Issue 28 reads after the first batch -> 28 rd_valid pulses, each one cycle after rd_en, data in write order (pixel0 ch0=0, ch15=0; pixel1 ch15=16); then fifo_empty=1, fifo_batch_ready=0.
- Write 64 pixels with no reads -> wr_ready=0 at count 64; 65th write dropped, overflow=1; read 1 + write 1 in the same cycle while full -> write rejected, count 63.
- Full frame of 196 pixels (7 batches, interleaved reads) -> fifo_last_batch=1 once 196 are written and rd_total>=168; after the 196th read, frame_done pulses for exactly 1 cycle and wr_ready returns next cycle.
- rd_en while empty right after reset -> underflow=1, rd_valid stays 0; assert rst_n=0 mid-frame (count 10) -> fifo_empty=1, flags cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath widths and per-layer geometry
package cnn_pkg;
  localparam int DATA_W = 8;
  localparam int CH     = 16;

  localparam int L2_IMG_W = 28;
  localparam int L2_IMG_H = 28;
  localparam int L3_IMG_W = 14;
  localparam int L3_IMG_H = 14;

  // L3 consumes two image rows per batch
  localparam int L3_TOTAL_PIXELS = L3_IMG_W * L3_IMG_H;
  localparam int L3_BATCH_SIZE   = 2 * L3_IMG_W;
endpackage

// File: rtl/fifo_mem_1r1w.sv
// rtl/fifo_mem_1r1w.sv - 1R1W register array, synchronous write, registered read
module fifo_mem_1r1w #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register holds the last read word until the next accepted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/l2_l3_batch_fifo.sv
// rtl/l2_l3_batch_fifo.sv - frame-aware batch FIFO between the L2 stage and conv2d_layer3
module l2_l3_batch_fifo #(
  parameter int CH           = cnn_pkg::CH,
  parameter int DATA_W       = cnn_pkg::DATA_W,
  parameter int DEPTH        = 64,
  parameter int BATCH_SIZE   = cnn_pkg::L3_BATCH_SIZE,
  parameter int TOTAL_PIXELS = cnn_pkg::L3_TOTAL_PIXELS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [CH*DATA_W-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [CH*DATA_W-1:0] rd_data,
  output logic                 fifo_empty,
  output logic                 fifo_batch_ready,
  output logic                 fifo_last_batch,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 underflow
);
  import cnn_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] BATCH_CNT = CW'(BATCH_SIZE);
  localparam logic [7:0]    TOTAL_C   = 8'(TOTAL_PIXELS);
  localparam logic [7:0]    BATCH_8   = 8'(BATCH_SIZE);
  localparam logic [7:0]    LAST_TH   = 8'(TOTAL_PIXELS - BATCH_SIZE);

  typedef enum logic [1:0] {S_FILL, S_TAIL, S_WRAP} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [7:0]     wr_total, rd_total;
  logic           wr_acc, rd_acc;

  // All status is decoded from registered state; inputs only qualify accepts
  assign wr_ready         = (count < DEPTH_C) && (wr_total < TOTAL_C) && (state != S_WRAP);
  assign fifo_empty       = (count == '0);
  assign fifo_batch_ready = (count >= BATCH_CNT);
  assign frame_done       = (state == S_WRAP);
  assign fifo_last_batch  = (state == S_TAIL) &&
                            ((rd_total >= LAST_TH) ||
                             ((count != '0) && (wr_total == TOTAL_C) &&
                              ((TOTAL_C - rd_total) <= BATCH_8)));

  assign wr_acc = wr_en && wr_ready;
  assign rd_acc = rd_en && !fifo_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (wr_acc && (wr_total == TOTAL_C - 8'd1)) state_nxt = S_TAIL;
      S_TAIL:  if (rd_acc && (rd_total == TOTAL_C - 8'd1)) state_nxt = S_WRAP;
      S_WRAP:  state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_total  <= '0;
      rd_total  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // The wrap cycle never accepts traffic, so clearing here loses nothing
      if (state == S_WRAP) begin
        wr_total <= '0;
        rd_total <= '0;
      end else begin
        if (wr_acc) wr_total <= wr_total + 8'd1;
        if (rd_acc) rd_total <= rd_total + 8'd1;
      end
      rd_valid  <= rd_acc;
      overflow  <= overflow | (wr_en & ~wr_ready);
      underflow <= underflow | (rd_en & fifo_empty);
    end
  end

  fifo_mem_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (CH*DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_l2_l3_batch_fifo.sv
// tb/tb_l2_l3_batch_fifo.sv - self-checking bench for l2_l3_batch_fifo against a queue model
module tb_l2_l3_batch_fifo;
  localparam int W     = 128;
  localparam int DEPTH = 64;
  localparam int BATCH = 28;
  localparam int TOTAL = 196;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         rd_en;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         fifo_empty, fifo_batch_ready, fifo_last_batch;
  logic         frame_done, overflow, underflow;

  always #5 clk = ~clk;

  l2_l3_batch_fifo dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready),
    .rd_en            (rd_en),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .fifo_empty       (fifo_empty),
    .fifo_batch_ready (fifo_batch_ready),
    .fifo_last_batch  (fifo_last_batch),
    .frame_done       (frame_done),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] q [$];
  int           m_wr_total, m_rd_total;
  bit           m_wrap, m_ovf, m_unf, m_rv;
  logic [W-1:0] m_rdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int idx);
    logic [W-1:0] v;
    for (int c = 0; c < 16; c++) v[8*c +: 8] = 8'((idx * (c + 1)) % 256);
    return v;
  endfunction

  function automatic bit exp_wr_ready();
    return (q.size() < DEPTH) && (m_wr_total < TOTAL) && !m_wrap;
  endfunction

  function automatic bit exp_last();
    return (m_wr_total == TOTAL) && !m_wrap && (m_rd_total >= TOTAL - BATCH);
  endfunction

  task automatic model_reset();
    q.delete();
    m_wr_total = 0; m_rd_total = 0;
    m_wrap = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
    m_rdata = '0;
  endtask

  task automatic check_outputs();
    chk1("wr_ready", wr_ready, exp_wr_ready());
    chk1("fifo_empty", fifo_empty, q.size() == 0);
    chk1("batch_ready", fifo_batch_ready, q.size() >= BATCH);
    chk1("last_batch", fifo_last_batch, exp_last());
    chk1("rd_valid", rd_valid, m_rv);
    chkw("rd_data", rd_data, m_rdata);
    chk1("frame_done", frame_done, m_wrap);
    chk1("overflow", overflow, m_ovf);
    chk1("underflow", underflow, m_unf);
  endtask

  // One clock: check settled outputs, drive, advance, update model
  task automatic step(input bit we, input logic [W-1:0] wd, input bit re);
    bit wacc, racc;
    check_outputs();
    wr_en = we; wr_data = wd; rd_en = re;
    wacc = we && exp_wr_ready();
    racc = re && (q.size() > 0);
    if (we && !exp_wr_ready()) m_ovf = 1;
    if (re && q.size() == 0)   m_unf = 1;
    @(posedge clk);
    if (m_wrap) begin
      m_wrap = 0; m_wr_total = 0; m_rd_total = 0;
    end
    m_rv = racc;
    if (racc) begin
      m_rdata = q.pop_front();
      m_rd_total++;
    end
    if (wacc) begin
      q.push_back(wd);
      m_wr_total++;
    end
    if (racc && m_rd_total == TOTAL) m_wrap = 1;
    @(negedge clk);
    wr_en = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  initial begin
    bit done, saw_last;
    int n;

    do_reset();
    check_outputs();

    // Read while empty straight after reset
    step(0, '0, 1);
    chk1("underflow_set", underflow, 1'b1);
    chk1("no_rv_on_underflow", rd_valid, 1'b0);
    do_reset();
    chk1("underflow_cleared", underflow, 1'b0);

    // First batch boundary
    for (int i = 0; i < 27; i++) step(1, pat(m_wr_total), 0);
    chk1("batch_not_ready_27", fifo_batch_ready, 1'b0);
    step(1, pat(m_wr_total), 0);
    chk1("batch_ready_28", fifo_batch_ready, 1'b1);
    chk1("not_empty_28", fifo_empty, 1'b0);

    // Drain the batch back-to-back
    for (int i = 0; i < 28; i++) begin
      step(0, '0, 1);
      if (i == 0) begin
        chk1("first_rv", rd_valid, 1'b1);
        chkw("pix0_ch0", {120'd0, rd_data[7:0]}, '0);
        chkw("pix0_ch15", {120'd0, rd_data[127:120]}, '0);
      end
      if (i == 1) chkw("pix1_ch15", {120'd0, rd_data[127:120]}, {120'd0, 8'd16});
    end
    chk1("drained_empty", fifo_empty, 1'b1);
    chk1("drained_batch", fifo_batch_ready, 1'b0);
    step(0, '0, 0);

    // Fill to capacity, overflow, then read+write while full
    for (int i = 0; i < 64; i++) step(1, pat(m_wr_total), 0);
    chk1("full_wr_ready", wr_ready, 1'b0);
    step(1, pat(m_wr_total), 0);
    chk1("overflow_set", overflow, 1'b1);
    step(1, pat(m_wr_total), 1);
    chk1("count63_wr_ready", wr_ready, 1'b1);
    step(1, pat(m_wr_total), 0);
    chk1("refull_wr_ready", wr_ready, 1'b0);

    // Finish the frame with randomized interleaved traffic
    done = 0; saw_last = 0; n = 0;
    while (!done && n < 4000) begin
      step($urandom_range(0, 99) < 60, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 99) < 50);
      if (fifo_last_batch === 1'b1) saw_last = 1;
      if (m_wrap) done = 1;
      n++;
    end
    chk1("frame_done_reached", done, 1'b1);
    chk1("last_batch_seen", saw_last, 1'b1);
    chk1("frame_done_pulse", frame_done, 1'b1);
    chk1("wrap_blocks_write", wr_ready, 1'b0);
    step(0, '0, 0);
    chk1("frame_done_one_cycle", frame_done, 1'b0);
    chk1("wr_ready_back", wr_ready, 1'b1);
    chk1("last_batch_cleared", fifo_last_batch, 1'b0);

    // Next frame: 10 pixels in, then asynchronous reset between edges
    for (int i = 0; i < 10; i++) step(1, pat(m_wr_total), 0);
    #2 rst_n = 0;
    #1;
    chk1("async_empty", fifo_empty, 1'b1);
    chk1("async_batch", fifo_batch_ready, 1'b0);
    chk1("async_last", fifo_last_batch, 1'b0);
    chk1("async_overflow", overflow, 1'b0);
    chk1("async_underflow", underflow, 1'b0);
    chk1("async_rv", rd_valid, 1'b0);
    chk1("async_wr_ready", wr_ready, 1'b1);
    chkw("async_rd_data", rd_data, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // Post-reset random traffic
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) == 0);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
